data_mem_sequencer: RTL
=======================

# data_mem_sequencer

Multi-cycle sequencer for the single-port data BRAM, driven by the decoded MemRead/MemWrite strobes and funct3 of the instruction in the memory stage. It performs aligned loads with byte/halfword extraction and sign/zero extension, full-word stores, and byte/halfword stores via read-modify-write. It stalls the pipeline until the access completes and flags misaligned or illegal accesses.

## Interface

- ADDR_W, 12, word-address width of the data BRAM (BRAM depth 2^ADDR_W words)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  load request (decoded MemRead)
- mem_write  in  1  store request (decoded MemWrite)
- funct3  in  3  access type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores: 0 SB, 1 SH, 2 SW
- addr  in  32  byte address; held stable by the pipeline while stall=1
- write_data  in  32  store data (rs2); held stable while stall=1
- read_data  out  32  extended load result, registered
- stall  out  1  pipeline hold, combinational
- misaligned  out  1  one-cycle error pulse, registered
- bram_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable (full word)
- bram_wdata  out  32  BRAM write data
- bram_rdata  in  32  BRAM read data, valid one cycle after a read enable

## Operation

- States: IDLE, RD, RMW_RD, RMW_WR, DONE.
- IDLE:
  - No request: stall=0, bram_en=0.
  - Any request: stall=1.
  - Aligned load: bram_en=1, we=0, go to RD.
  - Aligned SW: bram_en=1, we=1, wdata=write_data, go to DONE.
  - Aligned SB/SH: bram_en=1, we=0, go to RMW_RD.
- RD: extract from bram_rdata and register into read_data; stall=1; go to DONE.
  - LB/LBU: byte addr[1:0] (little-endian), sign- or zero-extended.
  - LH/LHU: halfword addr[1], sign- or zero-extended.
  - LW: the full word.
- RMW_RD: merge write_data[7:0] (SB, at byte addr[1:0]) or write_data[15:0] (SH, at halfword addr[1]) into bram_rdata; register the result in the merge register; stall=1; go to RMW_WR.
- RMW_WR: bram_en=1, we=1, wdata=merge register; stall=1; go to DONE.
- DONE: stall=0; read_data held; always go to IDLE. A request seen in DONE is the same instruction retiring and is ignored.
- Misaligned/illegal requests, detected in IDLE:
  - Cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
  - Response: no BRAM access, stall=1, read_data←0, misaligned=1 during DONE, go to DONE.
- mem_read and mem_write both high: treated as a load; write ignored.
- bram_addr always reflects the current addr input. The pipeline guarantees addr is stable while stall=1.

## Timing

- Reset:
  - state=IDLE, read_data=0, misaligned=0, merge register=0.
  - bram_en and bram_we forced to 0 in any cycle where reset=1.
  - stall=0 while reset=1.
- Latency, counted from the first request cycle (inclusive) to the release cycle:
  - Aligned load: 3 cycles (stall high 2 cycles); read_data valid in DONE and held until the next load or error.
  - SW: 2 cycles (stall high 1).
  - SB/SH: 4 cycles (stall high 3).
  - Misaligned/illegal: 2 cycles (stall high 1).
- Exactly one BRAM write per store. No write ever occurs in the reset cycle.
- Reset mid-operation aborts immediately, next state IDLE. A reset asserted in RMW_RD suppresses the pending write, leaving memory unchanged.
- misaligned is high for exactly one cycle per faulting request.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE. There is no dead cycle beyond DONE.

## Test plan

- Preload word 0x8000_00F0 at addr 0x10. LB addr 0x10 gives 0xFFFF_FFF0; LBU gives 0x0000_00F0; LH addr 0x12 gives 0xFFFF_8000; LHU addr 0x12 gives 0x0000_8000. Each releases stall after 2 stall cycles.
- SW 0xDEAD_BEEF to addr 0x20: one we=1 cycle with wdata=0xDEAD_BEEF and bram_addr=8; stall high 1 cycle; a subsequent LW returns 0xDEAD_BEEF.
- Word 0x1122_3344 at addr 0x30. SB 0xAA to addr 0x31 writes 0x1122_AA44. Then SH 0xBEEF to addr 0x32 writes 0xBEEF_AA44. Each store has stall high 3 cycles and exactly one write.
- LW at 0x41, SH at 0x43, and load funct3=3: misaligned pulses 1 cycle, no bram_en, read_data=0, stall high 1 cycle.
- Assert reset during RMW_RD of SB 0x55 to 0x50 (prior word 0x0): no write issued, state IDLE, stall=0; a later LW at 0x50 returns 0x0.
- Hold mem_read high continuously with different addresses: accesses occur every 3 cycles with no overlapping BRAM enables. mem_read and mem_write both high performs a load and no write.

Source files
------------

// File: rtl/data_mem_sequencer.sv
// Multi-cycle access sequencer for the single-port data BRAM: aligned loads with
// byte/halfword extraction, full-word stores, and sub-word stores via read-modify-write.
module data_mem_sequencer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              misaligned,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    output logic              bram_we,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] RMW_WR = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [2:0]  state_raw_s;
    logic [2:0]  f3_r;
    logic [31:0] merge_r;
    logic [31:0] read_data_r;
    logic        misaligned_r;
    logic        req_s;
    logic        fault_s;
    logic        stall_raw_s;
    logic        en_raw_s;
    logic        we_raw_s;
    logic        unused_addr_s;

    // Byte/halfword selection by address offset, followed by sign or zero extension.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'h000000, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'h0000, h};
            3'd2:    r = w;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Insert the low byte/halfword of the store data into the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] wd, input logic [31:0] old);
        logic [31:0] r;
        r = old;
        case (f3)
            3'd0: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = old;
                endcase
            end
            3'd1: begin
                if (off[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = old;
        endcase
        return r;
    endfunction

    assign req_s         = mem_read | mem_write;
    assign bram_addr     = addr[ADDR_W+1:2];
    assign read_data     = read_data_r;
    assign misaligned    = misaligned_r;
    assign unused_addr_s = ^addr[31:ADDR_W+2];

    // Alignment and funct3 legality check; a simultaneous read and write is a load.
    always_comb begin
        fault_s = 1'b0;
        if (mem_read) begin
            case (funct3)
                3'd0, 3'd4: fault_s = 1'b0;
                3'd1, 3'd5: fault_s = addr[0];
                3'd2:       fault_s = |addr[1:0];
                default:    fault_s = 1'b1;
            endcase
        end else if (mem_write) begin
            case (funct3)
                3'd0:    fault_s = 1'b0;
                3'd1:    fault_s = addr[0];
                3'd2:    fault_s = |addr[1:0];
                default: fault_s = 1'b1;
            endcase
        end else begin
            fault_s = 1'b0;
        end
    end

    // State transitions and BRAM command generation before reset gating.
    always_comb begin
        state_raw_s = state_r;
        stall_raw_s = 1'b0;
        en_raw_s    = 1'b0;
        we_raw_s    = 1'b0;
        bram_wdata  = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    stall_raw_s = 1'b1;
                    if (fault_s) begin
                        state_raw_s = DONE;
                    end else if (mem_read) begin
                        en_raw_s    = 1'b1;
                        state_raw_s = RD;
                    end else if (funct3 == 3'd2) begin
                        en_raw_s    = 1'b1;
                        we_raw_s    = 1'b1;
                        bram_wdata  = write_data;
                        state_raw_s = DONE;
                    end else begin
                        en_raw_s    = 1'b1;
                        state_raw_s = RMW_RD;
                    end
                end else begin
                    state_raw_s = IDLE;
                end
            end
            RD: begin
                stall_raw_s = 1'b1;
                state_raw_s = DONE;
            end
            RMW_RD: begin
                stall_raw_s = 1'b1;
                state_raw_s = RMW_WR;
            end
            RMW_WR: begin
                stall_raw_s = 1'b1;
                en_raw_s    = 1'b1;
                we_raw_s    = 1'b1;
                bram_wdata  = merge_r;
                state_raw_s = DONE;
            end
            // The request still visible in DONE is the retiring instruction.
            DONE: begin
                state_raw_s = IDLE;
            end
            default: begin
                state_raw_s = IDLE;
            end
        endcase
    end

    // Reset silences the BRAM and the stall in the very cycle it is asserted.
    always_comb begin
        if (reset) begin
            state_nxt_s = IDLE;
            stall       = 1'b0;
            bram_en     = 1'b0;
            bram_we     = 1'b0;
        end else begin
            state_nxt_s = state_raw_s;
            stall       = stall_raw_s;
            bram_en     = en_raw_s;
            bram_we     = we_raw_s;
        end
    end

    // State, access type, load result, merge word and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            f3_r         <= 3'd0;
            merge_r      <= 32'h0000_0000;
            read_data_r  <= 32'h0000_0000;
            misaligned_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            misaligned_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        f3_r <= funct3;
                        if (fault_s) begin
                            read_data_r  <= 32'h0000_0000;
                            misaligned_r <= 1'b1;
                        end
                    end
                end
                RD:      read_data_r <= load_extract(f3_r, addr[1:0], bram_rdata);
                RMW_RD:  merge_r     <= store_merge(f3_r, addr[1:0], write_data, bram_rdata);
                default: begin
                end
            endcase
        end
    end

endmodule
